// File: rtl/micro_sequencer_if.sv
// Bundle between the decoder/loader side and the micro_sequencer: sequencing
// inputs, microcode write port, and the control/status outputs.
interface micro_sequencer_if #(
  parameter int CWIDTH  = 24,
  parameter int OPWIDTH = 5,
  parameter int SWIDTH  = 3
);
  localparam int AWIDTH = OPWIDTH + SWIDTH;
  localparam int MWIDTH = CWIDTH + SWIDTH + 2;

  // mc_we is a single-cycle write strobe with no back-pressure: every cycle it
  // is high (outside reset) the store takes mc_wdata at mc_waddr on that edge.
  logic                run;
  logic [OPWIDTH-1:0]  inst;
  logic                cond;
  logic                stall;
  logic                mc_we;
  logic [AWIDTH-1:0]   mc_waddr;
  logic [MWIDTH-1:0]   mc_wdata;

  logic [CWIDTH-1:0]   control_signal;
  logic [SWIDTH-1:0]   stage;
  logic                busy;
  logic                instr_done;
  logic [31:0]         retire_count;
  logic                err;
  logic                dbg_state;

  modport master (
    output run, inst, cond, stall, mc_we, mc_waddr, mc_wdata,
    input  control_signal, stage, busy, instr_done, retire_count, err, dbg_state
  );

  modport slave (
    input  run, inst, cond, stall, mc_we, mc_waddr, mc_wdata,
    output control_signal, stage, busy, instr_done, retire_count, err, dbg_state
  );
endinterface

// File: rtl/micro_sequencer.sv
// Writable microcode store with an embedded stage sequencer: each microword
// selects its own successor stage, and completed instructions are counted.
module micro_sequencer #(
  parameter int                 CWIDTH     = 24,
  parameter int                 OPWIDTH    = 5,
  parameter int                 SWIDTH     = 3,
  parameter logic [CWIDTH-1:0]  STALL_MASK = 24'hE00000
) (
  input  logic             CLK,
  input  logic             RSTn,
  micro_sequencer_if.slave bus
);
  localparam int AWIDTH = OPWIDTH + SWIDTH;
  localparam int MWIDTH = CWIDTH + SWIDTH + 2;

  localparam logic [1:0] SEQ_NEXT  = 2'b00;
  localparam logic [1:0] SEQ_FETCH = 2'b01;
  localparam logic [1:0] SEQ_JUMP  = 2'b10;
  localparam logic [1:0] SEQ_COND  = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [SWIDTH-1:0]  stage_q, stage_nxt;
  logic [31:0]        count_q;
  logic               err_q;

  logic [MWIDTH-1:0]  mem [0:(1<<AWIDTH)-1];
  logic [MWIDTH-1:0]  word;
  logic [1:0]         seq;
  logic [SWIDTH-1:0]  target;
  logic [CWIDTH-1:0]  ctrl;

  logic               advance;
  logic               wrap;
  logic               finish;
  logic               busy_c;
  logic [CWIDTH-1:0]  ctrl_c;

  // Store is deliberately left out of reset so loaded microcode survives it.
  always_ff @(posedge CLK) begin
    if (RSTn && bus.mc_we) mem[bus.mc_waddr] <= bus.mc_wdata;
  end

  assign word   = mem[{bus.inst, stage_q}];
  assign seq    = word[MWIDTH-1 -: 2];
  assign target = word[CWIDTH +: SWIDTH];
  assign ctrl   = word[CWIDTH-1:0];

  assign advance = (state == RUN) && !bus.stall;
  // Falling off the last stage behaves like FETCH but raises err.
  assign wrap    = advance && (&stage_q) &&
                   ((seq == SEQ_NEXT) || ((seq == SEQ_COND) && !bus.cond));

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= IDLE;
      stage_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      stage_q <= stage_nxt;
      if (finish) count_q <= count_q + 32'd1;
      if (wrap)   err_q   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    stage_nxt = stage_q;
    case (state)
      IDLE: begin
        stage_nxt = '0;
        if (bus.run) state_nxt = RUN;
      end
      RUN: begin
        if (advance) begin
          if (finish) begin
            stage_nxt = '0;
            if (!bus.run) state_nxt = IDLE;
          end else begin
            case (seq)
              SEQ_NEXT: stage_nxt = stage_q + SWIDTH'(1);
              SEQ_JUMP: stage_nxt = target;
              SEQ_COND: stage_nxt = bus.cond ? target : stage_q + SWIDTH'(1);
              default:  stage_nxt = '0;
            endcase
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        stage_nxt = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy_c = 1'b0;
    ctrl_c = '0;
    finish = 1'b0;
    if (state == RUN) begin
      busy_c = 1'b1;
      ctrl_c = bus.stall ? (ctrl & ~STALL_MASK) : ctrl;
      finish = advance && ((seq == SEQ_FETCH) || wrap);
    end
  end

  assign bus.control_signal = ctrl_c;
  assign bus.stage          = stage_q;
  assign bus.busy           = busy_c;
  assign bus.instr_done     = finish;
  assign bus.retire_count   = count_q;
  assign bus.err            = err_q;
  assign bus.dbg_state      = state;
endmodule
